// File: rtl/pipe_alu_if.sv
// Handshake and result bus for pipe_alu: operation in, tagged result and condition codes out.
interface pipe_alu_if #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] tag_out;
  logic [3:0]       cc;
  logic [OCC_W-1:0] occupancy;

  modport master (
    output flush, in_valid, op, a, b, tag_in, out_ready,
    input  in_ready, out_valid, result, tag_out, cc, occupancy
  );

  modport slave (
    input  flush, in_valid, op, a, b, tag_in, out_ready,
    output in_ready, out_valid, result, tag_out, cc, occupancy
  );
endinterface

// File: rtl/pipe_alu.sv
// Elastic multi-stage ALU: result computed at accept, transported through STAGES
// collapsible registers; cc {V,C,N,Z} loads when an arithmetic/logic result is taken.
module pipe_alu #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2,
  parameter int TAG_W  = 6
) (
  input  logic      clk,
  input  logic      reset,
  pipe_alu_if.slave bus
);
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [STAGES-1:0] r_vld;
  logic [3:0]        r_op  [STAGES];
  logic [WIDTH-1:0]  r_res [STAGES];
  logic [3:0]        r_flg [STAGES];
  logic [TAG_W-1:0]  r_tag [STAGES];
  logic [3:0]        r_cc;

  logic [WIDTH:0]    w_sum;
  logic [WIDTH-1:0]  w_res;
  logic [3:0]        w_flg;
  logic              w_c;
  logic              w_v;
  logic [STAGES-1:0] w_adv;
  logic              w_space;
  logic              w_acc;
  logic              w_xfer;
  logic              w_cc_op;
  logic [OCC_W-1:0]  w_occ;

  always_comb begin
    w_sum = {1'b0, bus.a} + {1'b0, bus.b};
    w_res = bus.a;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.op)
      4'd1: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'd2: w_res = bus.a & bus.b;
      4'd3: w_res = {{(WIDTH-1){1'b0}}, |bus.a};
      4'd4: w_res = bus.a | bus.b;
      4'd5: begin
        w_res = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
        w_c   = bus.a[0];
      end
      4'd6: w_res = bus.a ^ bus.b;
      default: w_res = bus.a;
    endcase
    w_flg = {w_v, w_c, w_res[WIDTH-1], (w_res == '0)};
  end

  // Walk from the output back: a stage advances if the slot ahead is free or itself moving.
  always_comb begin
    w_adv   = '0;
    w_space = bus.out_ready && !bus.flush;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_adv[k] = r_vld[k] && w_space;
      w_space  = !r_vld[k] || w_adv[k];
    end
  end

  always_comb begin
    w_occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_occ = w_occ + OCC_W'(r_vld[k]);
    end
  end

  assign bus.in_ready  = !bus.flush && w_space;
  assign bus.out_valid = r_vld[STAGES-1] && !bus.flush;
  assign w_acc         = bus.in_valid && bus.in_ready;
  assign w_xfer        = bus.out_valid && bus.out_ready;
  assign w_cc_op       = (r_op[STAGES-1] >= 4'd1) && (r_op[STAGES-1] <= 4'd6);
  assign bus.result    = r_res[STAGES-1];
  assign bus.tag_out   = r_tag[STAGES-1];
  assign bus.cc        = r_cc;
  assign bus.occupancy = w_occ;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld <= '0;
      r_cc  <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_op[k]  <= '0;
        r_res[k] <= '0;
        r_flg[k] <= '0;
        r_tag[k] <= '0;
      end
    end else if (bus.flush) begin
      r_vld <= '0;
    end else begin
      if (!r_vld[0] || w_adv[0]) begin
        r_vld[0] <= w_acc;
        if (w_acc) begin
          r_op[0]  <= bus.op;
          r_res[0] <= w_res;
          r_flg[0] <= w_flg;
          r_tag[0] <= bus.tag_in;
        end
      end
      for (int k = 1; k < STAGES; k++) begin
        if (!r_vld[k] || w_adv[k]) begin
          r_vld[k] <= r_vld[k-1];
          if (r_vld[k-1]) begin
            r_op[k]  <= r_op[k-1];
            r_res[k] <= r_res[k-1];
            r_flg[k] <= r_flg[k-1];
            r_tag[k] <= r_tag[k-1];
          end
        end
      end
      if (w_xfer && w_cc_op) begin
        r_cc <= r_flg[STAGES-1];
      end
    end
  end
endmodule

// File: tb/tb_pipe_alu.sv
// Directed plus random bench for pipe_alu against a queue-based positional model.
module tb_pipe_alu;
  localparam int W = 16;
  localparam int S = 2;
  localparam int T = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_alu_if #(.WIDTH(W), .STAGES(S), .TAG_W(T)) u_if ();
  pipe_alu_if #(.WIDTH(8), .STAGES(1), .TAG_W(T)) u_if8 ();

  pipe_alu #(.WIDTH(W), .STAGES(S), .TAG_W(T)) u_dut (.clk(clk), .reset(reset), .bus(u_if));
  pipe_alu #(.WIDTH(8), .STAGES(1), .TAG_W(T)) u_dut8 (.clk(clk), .reset(reset), .bus(u_if8));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic [3:0]   op;
    logic [T-1:0] tag;
    int           pos;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_cc;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic void ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic [3:0] f);
    longint u, sa, sb, s;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      4'd1: begin
        u  = longint'(a) + longint'(b);
        r  = W'(u);
        c  = (u >= (longint'(1) << W));
        sa = $signed(a);
        sb = $signed(b);
        s  = sa + sb;
        v  = (s > ((longint'(1) << (W - 1)) - 1)) || (s < -(longint'(1) << (W - 1)));
      end
      4'd2: r = a & b;
      4'd3: r = (a != '0) ? W'(1) : '0;
      4'd4: r = a | b;
      4'd5: begin
        r = (a >> 1) | {a[W-1], {(W-1){1'b0}}};
        c = a[0];
      end
      4'd6: r = a ^ b;
      default: r = a;
    endcase
    f = {v, c, r[W-1], (r == '0)};
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model.
  task automatic step(input logic iv, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [T-1:0] tg, input logic ordy, input logic fl);
    ent_t e;
    logic m_rdy, m_ov, acc, xfer;
    int   lim, np;
    @(negedge clk);
    u_if.in_valid  = iv;
    u_if.op        = op;
    u_if.a         = a;
    u_if.b         = b;
    u_if.tag_in    = tg;
    u_if.out_ready = ordy;
    u_if.flush     = fl;
    #1;
    m_ov  = !fl && (q.size() > 0) && (q[0].pos == S - 1);
    m_rdy = !fl && ((q.size() < S) || (m_ov && ordy));
    chk("in_ready", 64'(u_if.in_ready), 64'(m_rdy));
    chk("out_valid", 64'(u_if.out_valid), 64'(m_ov));
    chk("occupancy", 64'(u_if.occupancy), 64'(q.size()));
    chk("cc", 64'(u_if.cc), 64'(m_cc));
    if (m_ov) begin
      chk("result", 64'(u_if.result), 64'(q[0].res));
      chk("tag_out", 64'(u_if.tag_out), 64'(q[0].tag));
    end
    acc  = iv && m_rdy;
    xfer = m_ov && ordy;
    if (fl) begin
      q.delete();
    end else begin
      if (xfer) begin
        if (q[0].op >= 4'd1 && q[0].op <= 4'd6) m_cc = q[0].flg;
        void'(q.pop_front());
      end
      for (int i = 0; i < q.size(); i++) begin
        e   = q[i];
        lim = (i == 0) ? S - 1 : q[i-1].pos - 1;
        np  = e.pos + 1;
        e.pos = (np < lim) ? np : lim;
        q[i] = e;
      end
      if (acc) begin
        ref_alu(op, a, b, e.res, e.flg);
        e.op  = op;
        e.tag = tg;
        e.pos = 0;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, '0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    u_if.flush = 0; u_if.in_valid = 0; u_if.op = 0; u_if.a = 0; u_if.b = 0;
    u_if.tag_in = 0; u_if.out_ready = 0;
    u_if8.flush = 0; u_if8.in_valid = 0; u_if8.op = 0; u_if8.a = 0; u_if8.b = 0;
    u_if8.tag_in = 0; u_if8.out_ready = 0;
    m_cc  = 4'b0000;
    reset = 1'b1;
    #3;
    chk("rst_in_ready", 64'(u_if.in_ready), 64'd1);
    chk("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    chk("rst_result", 64'(u_if.result), 64'd0);
    chk("rst_tag_out", 64'(u_if.tag_out), 64'd0);
    chk("rst_cc", 64'(u_if.cc), 64'd0);
    chk("rst_occupancy", 64'(u_if.occupancy), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // signed overflow on ADD
    step(1, 4'd1, 16'h7FFF, 16'h0001, 6'd5, 1, 0);
    idle(1);
    idle(1);
    chk("tp_add_valid", 64'(u_if.out_valid), 64'd1);
    chk("tp_add_res", 64'(u_if.result), 64'h8000);
    idle(1);
    chk("tp_add_cc", 64'(u_if.cc), 64'b1010);

    // back-to-back stream
    step(1, 4'd6, 16'h00FF, 16'h00FF, 6'd1, 1, 0);
    step(1, 4'd5, 16'h8001, 16'h0000, 6'd2, 1, 0);
    step(1, 4'd3, 16'h0000, 16'h0000, 6'd3, 1, 0);
    chk("str_xor_res", 64'(u_if.result), 64'h0000);
    step(1, 4'd7, 16'h1234, 16'h0000, 6'd4, 1, 0);
    chk("str_shr_res", 64'(u_if.result), 64'hC000);
    chk("str_cc_xor", 64'(u_if.cc), 64'b0001);
    idle(1);
    chk("str_any_res", 64'(u_if.result), 64'h0000);
    chk("str_cc_shr", 64'(u_if.cc), 64'b0110);
    idle(1);
    chk("str_dup_res", 64'(u_if.result), 64'h1234);
    chk("str_cc_any", 64'(u_if.cc), 64'b0001);
    idle(1);
    chk("str_cc_dup", 64'(u_if.cc), 64'b0001);

    // back-pressure, hold when full, pass-through on drain
    step(1, 4'd1, 16'h0001, 16'h0002, 6'd7, 0, 0);
    step(1, 4'd4, 16'h00F0, 16'h000F, 6'd8, 0, 0);
    step(1, 4'd6, 16'hAAAA, 16'h5555, 6'd9, 0, 0);
    chk("bp_full_rdy", 64'(u_if.in_ready), 64'd0);
    chk("bp_full_occ", 64'(u_if.occupancy), 64'd2);
    step(1, 4'd6, 16'hAAAA, 16'h5555, 6'd9, 0, 0);
    chk("bp_hold_res", 64'(u_if.result), 64'h0003);
    step(1, 4'd6, 16'hAAAA, 16'h5555, 6'd9, 1, 0);
    chk("bp_pass_rdy", 64'(u_if.in_ready), 64'd1);
    idle(1);
    idle(1);
    chk("bp_third_res", 64'(u_if.result), 64'hFFFF);
    idle(1);

    // flush with two ops in flight
    step(1, 4'd1, 16'h0003, 16'h0004, 6'd10, 0, 0);
    step(1, 4'd2, 16'hF0F0, 16'h0F0F, 6'd11, 0, 0);
    step(1, 4'd4, 16'h0001, 16'h0001, 6'd12, 1, 1);
    chk("fl_rdy", 64'(u_if.in_ready), 64'd0);
    chk("fl_ov", 64'(u_if.out_valid), 64'd0);
    idle(1);
    chk("fl_occ", 64'(u_if.occupancy), 64'd0);
    step(1, 4'd2, 16'h0000, 16'hFFFF, 6'd13, 1, 0);
    idle(1);
    idle(1);
    idle(1);

    // asynchronous reset between edges
    step(1, 4'd1, 16'h0001, 16'h0001, 6'd14, 0, 0);
    step(1, 4'd1, 16'h0002, 16'h0002, 6'd15, 0, 0);
    idle(0);
    chk("ar_occ_before", 64'(u_if.occupancy), 64'd2);
    chk("ar_cc_nonzero", 64'(u_if.cc != 4'b0000), 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_ov", 64'(u_if.out_valid), 64'd0);
    chk("ar_occ", 64'(u_if.occupancy), 64'd0);
    chk("ar_cc", 64'(u_if.cc), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    q.delete();
    m_cc = 4'b0000;

    // single-stage 8-bit instance
    @(negedge clk);
    u_if8.in_valid = 1; u_if8.op = 4'd1; u_if8.a = 8'hFF; u_if8.b = 8'h01;
    u_if8.tag_in = 6'd33; u_if8.out_ready = 1;
    #1;
    chk("s1_rdy", 64'(u_if8.in_ready), 64'd1);
    chk("s1_ov0", 64'(u_if8.out_valid), 64'd0);
    @(negedge clk);
    u_if8.in_valid = 0;
    #1;
    chk("s1_ov", 64'(u_if8.out_valid), 64'd1);
    chk("s1_res", 64'(u_if8.result), 64'h00);
    chk("s1_tag", 64'(u_if8.tag_out), 64'd33);
    @(negedge clk);
    #1;
    chk("s1_cc", 64'(u_if8.cc), 64'b0101);
    chk("s1_occ", 64'(u_if8.occupancy), 64'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), pick(), pick(),
           T'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 24) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_alu.md
# pipe_alu

Parametrised, elastic, multi-stage ALU that replaces the single-cycle combinational ALU in the processor's execute stage. It accepts one operation per cycle through a valid/ready handshake and carries a destination register tag alongside the data. The result comes out after a configurable number of pipeline stages. Back-pressure, bubble collapse, pipeline flush (for taken-jump squash) and a registered condition-code word with carry and overflow are all handled inside the block.

## Interface
- WIDTH, 16, operand/result width in bits (legal: 8..64).
- STAGES, 2, pipeline register stages from input to output (legal: 1..4).
- TAG_W, 6, width of the destination-register tag carried with each operation.
- clk  input  1  sole clock; all state changes on posedge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- flush  input  1  synchronous; discards every in-flight operation.
- in_valid  input  1  operation presented.
- in_ready  output  1  block accepts the operation this cycle.
- op  input  4  opcode, same encoding as the processor ISA (ADD=1, AND=2, ANY=3, OR=4, SHR=5, XOR=6, DUP=7).
- a  input  WIDTH  first operand (sole operand for ANY, SHR, DUP).
- b  input  WIDTH  second operand.
- tag_in  input  TAG_W  destination register index.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- result  output  WIDTH  result of the oldest in-flight operation.
- tag_out  output  TAG_W  tag of that operation.
- cc  output  4  {V, C, N, Z}, registered.
- occupancy  output  $clog2(STAGES+1)  number of valid stages.

## Operation
- Compute is combinational on the input operands. The result is captured into stage 0 on accept (in_valid && in_ready). Stages 1..STAGES-1 are pure transport.
- Each stage holds {valid, op, result, flags, tag}.
- Stage k loads from stage k-1 when stage k is empty or stage k advances. Bubbles therefore collapse.
- The last stage advances on out_valid && out_ready.
- Arithmetic:
  - ADD: result = a+b mod 2^WIDTH. C = carry out of bit WIDTH-1. V = signed overflow (a, b same sign, result differs).
  - AND, OR, XOR: bitwise. C=0, V=0.
  - ANY: result = 1 if a≠0, else 0. C=0, V=0.
  - SHR: arithmetic shift right by one, MSB preserved. C = a[0]. V=0.
  - DUP: result = a.
  - All other opcodes (0, 8..F): result = a.
  - N = result[WIDTH-1] and Z = (result==0) for every op.
- cc update:
  - cc updates only on an output transfer whose op is in 1..6; it loads that op's {V,C,N,Z}.
  - DUP and all other opcodes leave cc unchanged.
- flush:
  - While flush=1, in_ready=0 and out_valid=0; no transfer occurs in either direction.
  - At the edge, all valid bits clear. cc and the data registers are untouched.
- occupancy counts the set valid bits after each edge.

## Timing
- Reset values: in_ready=1, out_valid=0, result=0, tag_out=0, cc=4'b0000, occupancy=0. All stage data registers are 0.
- Latency: accept at edge t makes out_valid=1 after edge t+STAGES-1. The result is visible the cycle following the accept edge when STAGES=1.
- Throughput: one operation per cycle while out_ready=1.
- in_ready = !flush && (any stage empty || last stage advancing). This gives pass-through when full and out_ready=1.
- Full (occupancy=STAGES) with out_ready=0: in_ready=0, and all contents hold with stable result/tag_out.
- cc changes on the edge of the transfer that produced it, so the new cc is visible the cycle after the result was taken.
- flush and reset mid-operation:
  - flush and in_valid together: the operation is dropped.
  - flush and out_ready together: the result is not consumed and is discarded.
  - reset mid-operation: everything clears asynchronously, without waiting for clk.

## Test plan
- Reset, then with STAGES=2, WIDTH=16: ADD a=0x7FFF b=0x0001 with out_ready=1 -> result 0x8000 on the second cycle after accept. Next cycle cc={V1,C0,N1,Z0}.
- Back-to-back stream of XOR 0x00FF/0x00FF, SHR 0x8001, ANY 0x0000, DUP 0x1234 -> results 0x0000, 0xC000, 0x0000, 0x1234 on consecutive cycles. cc sequence {0,0,0,1}, {0,1,1,0}, {0,0,0,1}; DUP leaves cc unchanged.
- Hold out_ready=0 and issue 3 ops -> occupancy reaches 2 and in_ready drops after 2 accepts. Raising out_ready drains in order, and the third op is accepted in the same cycle as the first drain.
- Two ops in flight, assert flush one cycle with in_valid=1 -> no transfer that cycle, then occupancy=0, out_valid=0, cc unchanged. The next accepted op emerges normally.
- Assert reset asynchronously between edges with occupancy=2 and cc≠0 -> out_valid, occupancy and cc go to 0 before the next posedge.
- Rebuild with STAGES=1, WIDTH=8: ADD 0xFF+0x01 -> result 0x00 on the next cycle, then cc={V0,C1,N0,Z1}.
